bcd_nibble_seq: RTL and testbench
=================================

Name: bcd_nibble_seq

Overview:
Multi-cycle sequencer that runs 8- or 16-bit ADC/SBC through the single 4-bit binary/BCD nibble adder, one nibble per clock, least-significant first. It latches operands on a start handshake and chains carry between nibbles in a register. It writes result nibbles into a result register and produces the 65C816-style C/V/Z/N flags at completion. It sits between the CPU microsequencer (ALU op issue) and the nibble adder.

Parameters:
ZERO_UPPER, 0, in 8-bit mode: 1 = R[15:8] forced to 0x00; 0 = R[15:8] = latched A[15:8] (accumulator B passthrough).

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous, active-high reset.
START  in  1  request; sampled only in IDLE or DONE_ST.
ABORT  in  1  synchronous cancel; returns to IDLE, no DONE.
W16  in  1  1 = 16-bit (4 nibbles), 0 = 8-bit (2 nibbles); latched at START.
ADD  in  1  1 = add, 0 = subtract (B inverted per nibble); latched.
BCD  in  1  1 = decimal correction; latched.
CI  in  1  carry in (borrow-not for subtract); latched.
A  in  16  operand A; latched.
B  in  16  operand B; latched.
BUSY  out  1  high while nibbles are being processed.
DONE  out  1  one-cycle pulse: R and flags valid.
R  out  16  result.
CO  out  1  carry out of the last nibble.
VO  out  1  overflow from the last nibble.
ZO  out  1  result zero over active width.
NO  out  1  MSB of active width.

Behaviour:
- States: IDLE, RUN, DONE_ST. Reset → IDLE. Reset values: BUSY=0, DONE=0, R=0, CO=VO=ZO=NO=0, digit index=0, carry register=0.
- IDLE/DONE_ST with START=1 at edge k:
  - Latch A, B, W16, ADD, BCD, CI.
  - Carry register ← CI; index ← 0; state → RUN.
- RUN:
  - Each edge processes nibble idx. R[4*idx+3:4*idx] ← nibble sum; carry register ← nibble carry.
  - Nibble idx is registered at edge k+1+idx.
  - After the last nibble (N=2 or 4), at edge k+N, state → DONE_ST.
- Nibble semantics (per stage):
  - B' = B nibble XOR ~ADD; binary sum = A + B' + carry.
  - BCD add: if sum > 9 or carry out, add 6 and carry = 1.
  - BCD subtract: if no binary carry (borrow), subtract 6 (add 0xA) and carry = 0.
  - Binary mode: uncorrected sum and carry.
- Flag timing: CO, VO, ZO and NO update only at edge k+N; they hold otherwise.
  - VO = (A3 == B'3) & (A3 != binary-sum bit3) of the final nibble, using the pre-correction sum in BCD mode too.
  - ZO = (R[7:0]==0) in 8-bit mode, (R[15:0]==0) in 16-bit mode.
  - NO = R[7] or R[15].
- 8-bit mode: R[15:8] is set at edge k+1 per ZERO_UPPER.
- BUSY = 1 exactly in RUN (cycles after edges k..k+N-1). DONE = 1 exactly in DONE_ST, one cycle. Latency from the START edge to DONE high is N cycles.
- DONE_ST → IDLE next edge unless START=1, which starts a new op (back-to-back, throughput N+1).
- START in RUN: ignored, not queued.
- ABORT in RUN: → IDLE at next edge; R/flags keep partial values; no DONE. ABORT has priority over START in DONE_ST.
- RST asserted any time: immediate return to reset values; in-flight op discarded.
- Operand inputs may change after the START edge without effect.

Decomposition:
- Shared package: state encoding (IDLE/RUN/DONE_ST), nibble-count constants (2, 4), BCD correction constants (6, 0xA).
- One sub-module: the existing 4-bit nibble adder, instantiated once.
- Nibble mux/demux, carry register and FSM live in bcd_nibble_seq.

Test Plan:
1. W16=0, BCD=1, ADD=1, A=0x0045, B=0x0038, CI=0 → R[7:0]=0x83, CO=0, ZO=0, NO=1; DONE exactly 2 cycles after the START edge; BUSY high 2 cycles.
2. W16=1, BCD=1, ADD=1, A=0x9999, B=0x0001, CI=0 → R=0x0000, CO=1, ZO=1, NO=0; DONE 4 cycles after START.
3. W16=0, BCD=1, ADD=0, A=0x0000, B=0x0001, CI=1 → R[7:0]=0x99, CO=0, NO=1, ZO=0.
4. W16=1, BCD=0, ADD=1, A=0x7FFF, B=0x0001, CI=0 → R=0x8000, VO=1, NO=1, CO=0; and 0xFFFF+0x0001 → R=0x0000, CO=1, ZO=1, VO=0.
5. W16=0, A=0x12AB, B=0x0001: ZERO_UPPER=0 → R=0x12AC; ZERO_UPPER=1 → R=0x00AC.
6. Control edges:
   - START pulsed mid-RUN → ignored, single DONE.
   - START held in the DONE_ST cycle → second op completes N cycles later.
   - RST mid-RUN → BUSY=0, R=0 immediately, no DONE.
   - ABORT mid-RUN → IDLE, no DONE.

Source files
------------

// File: rtl/bcd_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial BCD/binary ADC/SBC sequencer:
// FSM state encoding, nibble counts and decimal correction constants.
package bcd_nibble_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    localparam int NIBBLES_8  = 2;
    localparam int NIBBLES_16 = 4;

    localparam logic [3:0] BCD_ADJ_ADD = 4'd6;
    localparam logic [3:0] BCD_ADJ_SUB = 4'hA;

    // Index of the final nibble for the selected operand width.
    function automatic logic [1:0] last_nibble(input logic w16);
        return w16 ? 2'(NIBBLES_16 - 1) : 2'(NIBBLES_8 - 1);
    endfunction

endpackage

// File: rtl/bcd_nibble_seq_adder.sv
// 4-bit binary/BCD nibble adder: one digit of ADC/SBC with decimal
// correction and a signed-overflow flag taken from the uncorrected sum.
module bcd_nibble_seq_adder
    import bcd_nibble_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    input  logic       add,
    input  logic       bcd,
    output logic [3:0] sum,
    output logic       co,
    output logic       vo
);

    logic [3:0] b_eff;
    logic [4:0] bin;

    always_comb begin
        b_eff = b ^ {4{~add}};
        bin   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, ci};
        sum   = bin[3:0];
        co    = bin[4];
        // Decimal correction: +6 on a digit overflow when adding, -6 (+0xA) on a borrow when subtracting.
        if (bcd) begin
            if (add) begin
                if (bin > 5'd9) begin
                    sum = bin[3:0] + BCD_ADJ_ADD;
                    co  = 1'b1;
                end
            end else if (!bin[4]) begin
                sum = bin[3:0] + BCD_ADJ_SUB;
                co  = 1'b0;
            end
        end
        vo = (a[3] == b_eff[3]) && (a[3] != bin[3]);
    end

endmodule

// File: rtl/bcd_nibble_seq.sv
// Nibble-serial 8/16-bit ADC/SBC sequencer: latches operands on START, runs
// one nibble per clock through a single nibble adder, then pulses DONE.
module bcd_nibble_seq
    import bcd_nibble_seq_pkg::*;
#(
    parameter bit ZERO_UPPER = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        ABORT,
    input  logic        W16,
    input  logic        ADD,
    input  logic        BCD,
    input  logic        CI,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] R,
    output logic        CO,
    output logic        VO,
    output logic        ZO,
    output logic        NO
);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        carry_q, carry_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        w16_q, w16_d;
    logic        add_q, add_d;
    logic        bcd_q, bcd_d;
    logic [15:0] r_q, r_d;
    logic        co_q, co_d;
    logic        vo_q, vo_d;
    logic        zo_q, zo_d;
    logic        no_q, no_d;

    logic [3:0]  bit_lo;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [3:0]  nib_sum;
    logic        nib_co;
    logic        nib_vo;
    logic        launch;

    assign bit_lo = {idx_q, 2'b00};
    assign nib_a  = a_q[bit_lo +: 4];
    assign nib_b  = b_q[bit_lo +: 4];

    bcd_nibble_seq_adder u_adder (
        .a   (nib_a),
        .b   (nib_b),
        .ci  (carry_q),
        .add (add_q),
        .bcd (bcd_q),
        .sum (nib_sum),
        .co  (nib_co),
        .vo  (nib_vo)
    );

    // ABORT wins over START whenever a new operation could be accepted.
    assign launch = START && !ABORT && ((state_q == IDLE) || (state_q == DONE_ST));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        w16_d   = w16_q;
        add_d   = add_q;
        bcd_d   = bcd_q;
        r_d     = r_q;
        co_d    = co_q;
        vo_d    = vo_q;
        zo_d    = zo_q;
        no_d    = no_q;

        case (state_q)
            IDLE, DONE_ST: begin
                if (launch) begin
                    a_d     = A;
                    b_d     = B;
                    w16_d   = W16;
                    add_d   = ADD;
                    bcd_d   = BCD;
                    carry_d = CI;
                    idx_d   = 2'd0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (ABORT) begin
                    idx_d   = 2'd0;
                    state_d = IDLE;
                end else begin
                    r_d[bit_lo +: 4] = nib_sum;
                    carry_d          = nib_co;
                    // In 8-bit mode the upper byte is either cleared or carries the B accumulator through.
                    if (!w16_q && (idx_q == 2'd0)) begin
                        r_d[15:8] = ZERO_UPPER ? 8'h00 : a_q[15:8];
                    end
                    if (idx_q == last_nibble(w16_q)) begin
                        idx_d   = 2'd0;
                        state_d = DONE_ST;
                        co_d    = nib_co;
                        vo_d    = nib_vo;
                        zo_d    = w16_q ? (r_d == 16'h0000) : (r_d[7:0] == 8'h00);
                        no_d    = w16_q ? r_d[15] : r_d[7];
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            carry_q <= 1'b0;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            w16_q   <= 1'b0;
            add_q   <= 1'b0;
            bcd_q   <= 1'b0;
            r_q     <= 16'h0000;
            co_q    <= 1'b0;
            vo_q    <= 1'b0;
            zo_q    <= 1'b0;
            no_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            w16_q   <= w16_d;
            add_q   <= add_d;
            bcd_q   <= bcd_d;
            r_q     <= r_d;
            co_q    <= co_d;
            vo_q    <= vo_d;
            zo_q    <= zo_d;
            no_q    <= no_d;
        end
    end

    assign BUSY = (state_q == RUN);
    assign DONE = (state_q == DONE_ST);
    assign R    = r_q;
    assign CO   = co_q;
    assign VO   = vo_q;
    assign ZO   = zo_q;
    assign NO   = no_q;

endmodule

// File: tb/tb_bcd_nibble_seq.sv
// Scoreboard bench for bcd_nibble_seq: two instances (ZERO_UPPER 0 and 1)
// share stimulus; a digit-level decimal/binary model predicts each result.
module tb_bcd_nibble_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        ABORT;
    logic        W16;
    logic        ADD;
    logic        BCD;
    logic        CI;
    logic [15:0] A;
    logic [15:0] B;

    logic        busy0, done0, co0, vo0, zo0, no0;
    logic [15:0] r0;
    logic        busy1, done1, co1, vo1, zo1, no1;
    logic [15:0] r1;

    typedef struct {
        logic [15:0] r0;
        logic [15:0] r1;
        logic        co;
        logic        vo;
        logic        zo;
        logic        no;
        int          n;
        int          start_edge;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    bcd_nibble_seq #(.ZERO_UPPER(1'b0)) u_dut0 (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .W16(W16), .ADD(ADD),
        .BCD(BCD), .CI(CI), .A(A), .B(B), .BUSY(busy0), .DONE(done0), .R(r0),
        .CO(co0), .VO(vo0), .ZO(zo0), .NO(no0)
    );

    bcd_nibble_seq #(.ZERO_UPPER(1'b1)) u_dut1 (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .W16(W16), .ADD(ADD),
        .BCD(BCD), .CI(CI), .A(A), .B(B), .BUSY(busy1), .DONE(done1), .R(r1),
        .CO(co1), .VO(vo1), .ZO(zo1), .NO(no1)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: digit-by-digit decimal or binary arithmetic on whole numbers.
    function automatic exp_t model(input logic w16, input logic add, input logic bcd,
                                   input logic ci, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        int          n, carry, an, bn, bp, raw, dig, t;
        logic [15:0] res;
        n     = w16 ? 4 : 2;
        carry = ci ? 1 : 0;
        res   = 16'h0000;
        e.vo  = 1'b0;
        for (int i = 0; i < n; i++) begin
            an  = int'((a >> (4 * i)) & 16'h000F);
            bn  = int'((b >> (4 * i)) & 16'h000F);
            bp  = add ? bn : 15 - bn;
            raw = an + bp + carry;
            e.vo = ((an >> 3) == (bp >> 3)) && ((an >> 3) != ((raw >> 3) & 1));
            if (!bcd) begin
                dig   = raw & 15;
                carry = raw >> 4;
            end else if (add) begin
                t = an + bn + carry;
                if (t > 9) begin
                    dig   = (t - 10) & 15;
                    carry = 1;
                end else begin
                    dig   = t;
                    carry = 0;
                end
            end else begin
                t = an - bn - (1 - carry);
                if (t < 0) begin
                    dig   = (t + 10) & 15;
                    carry = 0;
                end else begin
                    dig   = t;
                    carry = 1;
                end
            end
            res = res | 16'(dig << (4 * i));
        end
        e.co = (carry != 0);
        e.zo = w16 ? (res == 16'h0000) : (res[7:0] == 8'h00);
        e.no = w16 ? res[15] : res[7];
        e.r0 = res;
        e.r1 = res;
        if (!w16) begin
            e.r0[15:8] = a[15:8];
            e.r1[15:8] = 8'h00;
        end
        e.n          = n;
        e.start_edge = 0;
        return e;
    endfunction

    // Issues one START (caller guarantees IDLE/DONE_ST); returns at the negedge after the START edge.
    task automatic applyStimulus(input logic w16, input logic add, input logic bcd,
                                 input logic ci, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e = model(w16, add, bcd, ci, a, b);
        W16   = w16;
        ADD   = add;
        BCD   = bcd;
        CI    = ci;
        A     = a;
        B     = b;
        START = 1'b1;
        e.start_edge = cyc + 1;
        @(posedge CLK);
        expq.push_back(e);
        @(negedge CLK);
        START = 1'b0;
        A     = 16'($urandom);
        B     = 16'($urandom);
        W16   = 1'($urandom);
        ADD   = 1'($urandom);
        BCD   = 1'($urandom);
        CI    = 1'($urandom);
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while (expq.size() != 0 && t < 40) begin
            @(negedge CLK);
            t++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got %0d pending results expected 0", expq.size());
            expq.delete();
        end
        @(negedge CLK);
    endtask

    task automatic runOp(input logic w16, input logic add, input logic bcd,
                         input logic ci, input logic [15:0] a, input logic [15:0] b);
        applyStimulus(w16, add, bcd, ci, a, b);
        waitDrain();
    endtask

    // Monitor: pops one expected result per DONE pulse and checks latency and BUSY length.
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            busy_cnt = 0;
        end else begin
            if (busy0) begin
                busy_cnt++;
            end else if (!done0) begin
                busy_cnt = 0;
            end
            if (done0) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got DONE=1 expected DONE=0 (cycle %0d)", cyc);
                end else begin
                    e = expq.pop_front();
                    checkOutput("r_zu0", 32'(r0), 32'(e.r0));
                    checkOutput("r_zu1", 32'(r1), 32'(e.r1));
                    checkOutput("co", 32'(co0), 32'(e.co));
                    checkOutput("vo", 32'(vo0), 32'(e.vo));
                    checkOutput("zo", 32'(zo0), 32'(e.zo));
                    checkOutput("no", 32'(no0), 32'(e.no));
                    checkOutput("done_zu1", 32'(done1), 32'd1);
                    checkOutput("flags_zu1", 32'({co1, vo1, zo1, no1}), 32'({e.co, e.vo, e.zo, e.no}));
                    checkOutput("busy_at_done", 32'({busy0, busy1}), 32'd0);
                    checkOutput("latency", 32'(cyc - e.start_edge), 32'(e.n));
                    checkOutput("busy_cycles", 32'(busy_cnt), 32'(e.n));
                end
                busy_cnt = 0;
            end else if (done1) begin
                checks++;
                errors++;
                $display("[TB] FAIL done_zu1_alone: got DONE=1 expected DONE=0 (cycle %0d)", cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        logic w, ad, bc, c;
        RST   = 1'b1;
        START = 1'b0;
        ABORT = 1'b0;
        W16   = 1'b0;
        ADD   = 1'b1;
        BCD   = 1'b0;
        CI    = 1'b0;
        A     = 16'h0000;
        B     = 16'h0000;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        checkOutput("reset_busy_done", 32'({busy0, done0, busy1, done1}), 32'd0);
        checkOutput("reset_r", 32'(r0), 32'h0);
        checkOutput("reset_flags", 32'({co0, vo0, zo0, no0}), 32'd0);

        $display("[TB] directed arithmetic cases");
        runOp(1'b0, 1'b1, 1'b1, 1'b0, 16'h0045, 16'h0038);
        checkOutput("bcd8_add_r", 32'(r0), 32'h0083);
        runOp(1'b1, 1'b1, 1'b1, 1'b0, 16'h9999, 16'h0001);
        checkOutput("bcd16_wrap", 32'({r0, co0, zo0, no0}), 32'({16'h0000, 3'b110}));
        runOp(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001);
        checkOutput("bcd8_sub_r", 32'(r0[7:0]), 32'h99);
        runOp(1'b1, 1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h0001);
        checkOutput("bin16_ovf", 32'({r0, vo0, no0, co0}), 32'({16'h8000, 3'b110}));
        runOp(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
        checkOutput("bin16_carry", 32'({r0, co0, zo0, vo0}), 32'({16'h0000, 3'b110}));
        runOp(1'b0, 1'b1, 1'b0, 1'b0, 16'h12AB, 16'h0001);
        checkOutput("upper_zu", 32'({r0, r1}), 32'({16'h12AC, 16'h00AC}));

        $display("[TB] START pulsed mid-RUN");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h1111);
        START = 1'b1;
        A     = 16'h5555;
        @(negedge CLK);
        START = 1'b0;
        waitDrain();
        repeat (6) @(negedge CLK);

        $display("[TB] back-to-back START in DONE cycle");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0019, 16'h0028);
        repeat (2) @(negedge CLK);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h1000, 16'h0001);
        waitDrain();

        $display("[TB] reset mid-RUN");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        checkOutput("rst_busy_done", 32'({busy0, done0}), 32'd0);
        checkOutput("rst_r", 32'(r0), 32'h0);
        @(negedge CLK);
        expq.delete();
        RST = 1'b0;
        repeat (8) @(negedge CLK);

        $display("[TB] ABORT mid-RUN");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h1239, 16'h0004);
        @(negedge CLK);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        e = expq.pop_back();
        checkOutput("abort_busy", 32'(busy0), 32'd0);
        checkOutput("abort_partial_nib0", 32'(r0[3:0]), 32'(e.r0[3:0]));
        repeat (8) @(negedge CLK);

        $display("[TB] ABORT beats START in DONE cycle");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0020);
        repeat (2) @(negedge CLK);
        START = 1'b1;
        ABORT = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        ABORT = 1'b0;
        checkOutput("abort_over_start", 32'({busy0, done0}), 32'd0);
        repeat (6) @(negedge CLK);

        $display("[TB] randomized operations");
        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom);
            ad = 1'($urandom);
            bc = 1'($urandom);
            c  = 1'($urandom);
            applyStimulus(w, ad, bc, c, 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 2) == 0 && i != 59) begin
                repeat (w ? 4 : 2) @(negedge CLK);
            end else begin
                waitDrain();
            end
        end
        waitDrain();
        repeat (4) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
